func_unit_arbiter: RTL
======================

# func_unit_arbiter

Sequential controller that shares one combinational math function unit between two requesters. The unit computes Y=2x+2 for op 01, Y=x*x for op 10, and 0 otherwise, from a 4-bit operand and a 2-bit selector, giving an 8-bit result. This block sits between the two operand sources (switch banks or upstream FSMs) and the function unit, ahead of the 7-segment decoder. It does round-robin arbitration, latches operands, drives the unit, waits a programmable settling time, registers the result and signals completion.

## Interface
- WAIT_CYCLES, default 1: settling cycles between operand drive and result capture. 0 is treated as 1.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1 each  request from requester 0 / 1, level-sensitive
- x0 / x1  in  4 each  operand of requester 0 / 1; stable while its req is high
- op0 / op1  in  2 each  function select of requester 0 / 1
- fu_binario  out  4  operand driven to the function unit
- fu_sel  out  2  selector driven to the function unit
- fu_result  in  8  result returned by the function unit (combinational)
- gnt0 / gnt1  out  1 each  one-cycle pulse: operands of that requester latched
- done0 / done1  out  1 each  one-cycle pulse: result for that requester valid on result
- result  out  8  registered result, held until the next capture
- busy  out  1  high in GRANT and WAIT states

## Operation
- States: IDLE, GRANT, WAIT.
- IDLE: sample req0/req1 at each edge.
  - None high: stay in IDLE.
  - One high: serve it.
  - Both high: serve the requester selected by the priority pointer `ptr`.
- On accepting requester i:
  - latch x_i and op_i into the operand registers;
  - go to GRANT and load the wait counter with max(WAIT_CYCLES,1).
- GRANT lasts one cycle:
  - gnt_i=1;
  - fu_binario/fu_sel driven from the operand registers;
  - next state is WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter equals 1:
  - result<=fu_result;
  - done_i=1 for the following cycle;
  - `ptr` <= the other requester;
  - state<=IDLE.
- The done cycle is an IDLE cycle, so a new request can be sampled at its closing edge.
- fu_binario/fu_sel come only from the operand registers. They hold their last value in IDLE.
- Requester protocol:
  - a requester must deassert req no later than the done cycle;
  - req still high at the closing edge of done_i is a new request;
  - with both reqs held high, service alternates 0,1,0,1.
- Invalid ops (00, 11) get no special handling: they are issued normally and the result is whatever the unit returns (0).
- No arithmetic is done here; width is 8 bits end to end. The maximum value is 225.

## Timing
- Reset (async, immediate):
  - state=IDLE, ptr=0, counter=0;
  - fu_binario=0, fu_sel=00, result=0x00;
  - gnt0/gnt1/done0/done1/busy=0.
- Req sampled high at edge E0:
  - gnt_i high in cycle E0..E1;
  - capture at edge E0+1+WAIT_CYCLES;
  - done_i high for exactly one cycle after that edge.
- Latency req-sample to done = WAIT_CYCLES+1 edges. Default: 2.
- Throughput: one operation per WAIT_CYCLES+2 cycles under continuous requests.
- gnt and done are single-cycle, never asserted together, and never asserted for both requesters in the same cycle.
- busy is high from the GRANT cycle through the last WAIT cycle. It is low during the done cycle.
- A request arriving while busy is not lost if held; it is served at the next IDLE sample.
- Reset mid-operation: the operation is abandoned, no done pulse is generated, and all outputs return to their reset values.
- After reset release, the first simultaneous request goes to requester 0.

## Test plan
- Reset: hold rst_n=0 mid-WAIT with WAIT_CYCLES=3 -> all outputs zero immediately; no done after release; ptr=0.
- Single request: req0, x0=5, op0=01 -> gnt0 one cycle after sample, done0 two edges after sample, result=0x0C, fu_binario=5, fu_sel=01.
- Square, max value: req1, x1=15, op1=10 -> done1 pulse, result=0xE1. Also op1=01, x1=15 -> result=0x20.
- Simultaneous: req0 and req1 both held, x0=3/op 10, x1=2/op 01 ->
  - order 0,1,0,1;
  - results alternate 0x09, 0x06;
  - never two gnts in one cycle.
- Invalid op: op0=11, x0=7 -> normal gnt0/done0 sequence, result=0x00.
- WAIT_CYCLES=4, and separately WAIT_CYCLES=0:
  - 4 -> done 5 edges after sample, result stable until the next capture;
  - 0 -> behaves exactly as 1.

Source files
------------

// File: rtl/func_unit_arbiter.sv
// Round-robin front end that time-shares one combinational function unit between
// two requesters: latch operands, drive the unit, wait for settling, capture result.
module func_unit_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] x0,
  input  logic [3:0] x1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  output logic [3:0] fu_binario,
  output logic [1:0] fu_sel,
  input  logic [7:0] fu_result,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       busy
);

  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF < 2) ? 1 : $clog2(WAIT_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

  state_t           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       opnd_q;
  logic [1:0]       sel_q;
  logic [7:0]       result_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q;

  logic accept_d;
  logic pick1_d;

  // Requester 1 wins when it is alone or when both ask and the pointer favours it.
  always_comb begin
    accept_d = req0 | req1;
    pick1_d  = req1 & (~req0 | ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= 4'd0;
      sel_q    <= 2'b00;
      result_q <= 8'h00;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            owner_q <= pick1_d;
            opnd_q  <= pick1_d ? x1 : x0;
            sel_q   <= pick1_d ? op1 : op0;
            cnt_q   <= CNT_LOAD;
            gnt0_q  <= ~pick1_d;
            gnt1_q  <= pick1_d;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: state_q <= S_WAIT;
        S_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            result_q <= fu_result;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            ptr_q    <= ~owner_q;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fu_binario = opnd_q;
  assign fu_sel     = sel_q;
  assign result     = result_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign busy       = busy_q;

endmodule
